// File: rtl/updn_counter_pkg.sv
// Shared encodings for the parameterised up/down counter.
package updn_counter_pkg;

  // Overflow policy selected through the MODE parameter
  localparam int unsigned MODE_WRAP = 0;
  localparam int unsigned MODE_SAT  = 1;

  // Operation chosen for the current edge after priority decode
  typedef enum logic [2:0] {
    OP_HOLD  = 3'd0,
    OP_LOAD  = 3'd1,
    OP_CLAMP = 3'd2,
    OP_UP    = 3'd3,
    OP_DOWN  = 3'd4
  } op_e;

endpackage

// File: rtl/updn_next_calc.sv
// Combinational next-count arithmetic with wrap/saturate policy and flags.
module updn_next_calc
  import updn_counter_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned MODE  = MODE_WRAP
) (
  input  logic             dn,
  input  logic [WIDTH-1:0] count,
  input  logic [WIDTH-1:0] step,
  input  logic [WIDTH-1:0] max_val,
  output logic [WIDTH-1:0] next,
  output logic             ovf,
  output logic             unf
);

  logic [WIDTH:0] cnt_x;
  logic [WIDTH:0] max_x;
  logic [WIDTH:0] s_x;
  logic [WIDTH:0] sum_x;

  // Widen operands by one bit so sums and wrap terms never truncate
  always_comb begin
    cnt_x = {1'b0, count};
    max_x = {1'b0, max_val};
    s_x   = (step > max_val) ? max_x : {1'b0, step};
    sum_x = cnt_x + s_x;
    next  = count;
    ovf   = 1'b0;
    unf   = 1'b0;
    if (max_val == '0) begin
      // Single-value range: count is pinned, every non-zero request flags
      next = '0;
      if (step != '0) begin
        if (dn) unf = 1'b1;
        else    ovf = 1'b1;
      end
    end else if (!dn) begin
      if (sum_x > max_x) begin
        ovf  = 1'b1;
        next = (MODE == MODE_SAT) ? max_val : WIDTH'(sum_x - max_x - 1'b1);
      end else begin
        next = WIDTH'(sum_x);
      end
    end else begin
      if (s_x > cnt_x) begin
        unf  = 1'b1;
        next = (MODE == MODE_SAT) ? '0 : WIDTH'(cnt_x + max_x + 1'b1 - s_x);
      end else begin
        next = WIDTH'(cnt_x - s_x);
      end
    end
  end

endmodule

// File: rtl/updn_counter_param.sv
// Parameterised up/down counter with programmable range, step and load.
module updn_counter_param
  import updn_counter_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned MODE  = MODE_WRAP
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic             up,
  input  logic             down,
  input  logic [WIDTH-1:0] data,
  input  logic [WIDTH-1:0] step,
  input  logic [WIDTH-1:0] max_val,
  output logic [WIDTH-1:0] count,
  output logic             at_max,
  output logic             at_min,
  output logic             ovf,
  output logic             unf
);

  op_e              op;
  logic [WIDTH-1:0] calc_next;
  logic             calc_ovf;
  logic             calc_unf;

  // Priority decode of the per-edge operation (reset handled in the register)
  always_comb begin
    op = OP_HOLD;
    if (load)                op = OP_LOAD;
    else if (count > max_val) op = OP_CLAMP;
    else if (!en)            op = OP_HOLD;
    else if (up && down)     op = OP_HOLD;
    else if (up)             op = OP_UP;
    else if (down)           op = OP_DOWN;
  end

  updn_next_calc #(
    .WIDTH (WIDTH),
    .MODE  (MODE)
  ) u_calc (
    .dn      (op == OP_DOWN),
    .count   (count),
    .step    (step),
    .max_val (max_val),
    .next    (calc_next),
    .ovf     (calc_ovf),
    .unf     (calc_unf)
  );

  // Count and one-cycle flag registers
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
      ovf   <= 1'b0;
      unf   <= 1'b0;
    end else begin
      ovf <= 1'b0;
      unf <= 1'b0;
      case (op)
        OP_LOAD:  count <= (data > max_val) ? max_val : data;
        OP_CLAMP: count <= max_val;
        OP_UP: begin
          count <= calc_next;
          ovf   <= calc_ovf;
        end
        OP_DOWN: begin
          count <= calc_next;
          unf   <= calc_unf;
        end
        default:  count <= count;
      endcase
    end
  end

  // Range indicators follow count directly
  always_comb begin
    at_max = (count == max_val);
    at_min = (count == '0);
  end

endmodule

// File: tb/tb_updn_counter_param.sv
// Directed-vector bench for updn_counter_param (WRAP/SAT at 4 bits, WRAP at 8 bits).
module tb_updn_counter_param;

  logic       clk = 1'b0;
  logic       rst, en, load, up, down;
  logic [3:0] data, step, max_val;
  logic [7:0] data8, step8, max8;

  logic [3:0] cw, cs;
  logic [7:0] c8;
  logic       amaxw, aminw, ow, uw;
  logic       amaxs, amins, os, us;
  logic       amax8, amin8, o8, u8;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  updn_counter_param #(.WIDTH(4), .MODE(0)) d_w (
    .clk(clk), .rst(rst), .en(en), .load(load), .up(up), .down(down),
    .data(data), .step(step), .max_val(max_val),
    .count(cw), .at_max(amaxw), .at_min(aminw), .ovf(ow), .unf(uw)
  );

  updn_counter_param #(.WIDTH(4), .MODE(1)) d_s (
    .clk(clk), .rst(rst), .en(en), .load(load), .up(up), .down(down),
    .data(data), .step(step), .max_val(max_val),
    .count(cs), .at_max(amaxs), .at_min(amins), .ovf(os), .unf(us)
  );

  updn_counter_param #(.WIDTH(8), .MODE(0)) d8 (
    .clk(clk), .rst(rst), .en(en), .load(load), .up(up), .down(down),
    .data(data8), .step(step8), .max_val(max8),
    .count(c8), .at_max(amax8), .at_min(amin8), .ovf(o8), .unf(u8)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; load = 1'b1; up = 1'b1; down = 1'b0;
    data = 4'd5; step = 4'd1; max_val = 4'd15;
    tick();
    vectors++;
    if ({cw, ow, uw, aminw, amaxw} !== {4'd0, 1'b0, 1'b0, 1'b1, 1'b0}) begin
      $display("FAIL reset_w: got %b expected %b", {cw, ow, uw, aminw, amaxw}, 8'b0000_0010);
      miscompares++;
    end
    vectors++;
    if ({cs, os, us, amins, amaxs} !== {4'd0, 1'b0, 1'b0, 1'b1, 1'b0}) begin
      $display("FAIL reset_s: got %b expected %b", {cs, os, us, amins, amaxs}, 8'b0000_0010);
      miscompares++;
    end
    max_val = 4'd0;
    #1;
    vectors++;
    if ({amaxw, aminw} !== 2'b11) begin
      $display("FAIL reset_atmax_zero: got %b expected 11", {amaxw, aminw});
      miscompares++;
    end
    max_val = 4'd15;
    tick();
  endtask

  task automatic test_wrap_step1();
    logic [3:0] exp;
    rst = 1'b0; en = 1'b1; load = 1'b1; up = 1'b0; down = 1'b0;
    max_val = 4'd15; step = 4'd1; data = 4'd10;
    tick();
    vectors++;
    if (cw !== 4'd10) begin
      $display("FAIL v1_load: got %0d expected 10", cw);
      miscompares++;
    end
    load = 1'b0; up = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      exp = 4'(11 + i);
      vectors++;
      if ({cw, ow, uw} !== {exp, (exp == 4'd0), 1'b0}) begin
        $display("FAIL v1_up%0d: got cnt=%0d ovf=%b unf=%b expected cnt=%0d ovf=%b unf=0",
                 i, cw, ow, uw, exp, (exp == 4'd0));
        miscompares++;
      end
    end
  endtask

  task automatic test_wrap_step3();
    logic [5:0] exp [4] = '{{4'd1, 1'b1, 1'b0}, {4'd4, 1'b0, 1'b0},
                            {4'd1, 1'b0, 1'b0}, {4'd8, 1'b0, 1'b1}};
    load = 1'b1; up = 1'b0; down = 1'b0; max_val = 4'd9; step = 4'd3; data = 4'd8;
    tick();
    vectors++;
    if (cw !== 4'd8) begin
      $display("FAIL v2_load: got %0d expected 8", cw);
      miscompares++;
    end
    load = 1'b0;
    for (int i = 0; i < 4; i++) begin
      up = (i < 2); down = (i >= 2);
      tick();
      vectors++;
      if ({cw, ow, uw} !== exp[i]) begin
        $display("FAIL v2_step%0d: got {cnt,ovf,unf}=%b expected %b", i, {cw, ow, uw}, exp[i]);
        miscompares++;
      end
    end
  endtask

  task automatic test_saturate();
    logic [5:0] exp [5] = '{{4'd12, 1'b1, 1'b0}, {4'd12, 1'b1, 1'b0}, {4'd7, 1'b0, 1'b0},
                            {4'd2, 1'b0, 1'b0}, {4'd0, 1'b0, 1'b1}};
    load = 1'b1; up = 1'b0; down = 1'b0; max_val = 4'd12; step = 4'd5; data = 4'd10;
    tick();
    vectors++;
    if (cs !== 4'd10) begin
      $display("FAIL v3_load: got %0d expected 10", cs);
      miscompares++;
    end
    load = 1'b0;
    for (int i = 0; i < 5; i++) begin
      up = (i < 2); down = (i >= 2);
      tick();
      vectors++;
      if ({cs, os, us} !== exp[i]) begin
        $display("FAIL v3_step%0d: got {cnt,ovf,unf}=%b expected %b", i, {cs, os, us}, exp[i]);
        miscompares++;
      end
    end
    vectors++;
    if ({amins, amaxs} !== 2'b10) begin
      $display("FAIL v3_atmin: got %b expected 10", {amins, amaxs});
      miscompares++;
    end
  endtask

  task automatic test_hold_priority();
    load = 1'b1; up = 1'b0; down = 1'b0; max_val = 4'd15; step = 4'd1; data = 4'd5; en = 1'b1;
    tick();
    load = 1'b0;
    for (int i = 0; i < 6; i++) begin
      en = (i >= 3) ? 1'b0 : 1'b1;
      up = 1'b1; down = (i < 3);
      tick();
      vectors++;
      if ({cw, ow, uw} !== {4'd5, 1'b0, 1'b0}) begin
        $display("FAIL v4_hold%0d: got {cnt,ovf,unf}=%b expected %b", i, {cw, ow, uw}, 6'b0101_00);
        miscompares++;
      end
    end
    en = 1'b1; down = 1'b0; up = 1'b1; load = 1'b1; data = 4'd3;
    tick();
    vectors++;
    if ({cw, ow, uw} !== {4'd3, 1'b0, 1'b0}) begin
      $display("FAIL v4_load_over_up: got {cnt,ovf,unf}=%b expected %b", {cw, ow, uw}, 6'b0011_00);
      miscompares++;
    end
  endtask

  task automatic test_clamp();
    load = 1'b1; up = 1'b0; down = 1'b0; data = 4'd14; max_val = 4'd15;
    tick();
    load = 1'b0; en = 1'b0; max_val = 4'd6;
    tick();
    vectors++;
    if ({cw, ow, uw, amaxw} !== {4'd6, 1'b0, 1'b0, 1'b1}) begin
      $display("FAIL v5_clamp: got {cnt,ovf,unf,atmax}=%b expected %b", {cw, ow, uw, amaxw}, 7'b0110_001);
      miscompares++;
    end
    load = 1'b1; data = 4'd11;
    tick();
    vectors++;
    if (cw !== 4'd6) begin
      $display("FAIL v5_load_limit: got %0d expected 6", cw);
      miscompares++;
    end
    en = 1'b1; load = 1'b0;
  endtask

  task automatic test_reset_midcount();
    load = 1'b1; up = 1'b0; down = 1'b0; max_val = 4'd15; step = 4'd1; data = 4'd6;
    tick();
    load = 1'b0; up = 1'b1;
    tick();
    vectors++;
    if (cw !== 4'd7) begin
      $display("FAIL v6_pre: got %0d expected 7", cw);
      miscompares++;
    end
    rst = 1'b1; load = 1'b1; data = 4'd9;
    tick();
    vectors++;
    if ({cw, ow, uw} !== {4'd0, 1'b0, 1'b0}) begin
      $display("FAIL v6_rst: got {cnt,ovf,unf}=%b expected 000000", {cw, ow, uw});
      miscompares++;
    end
    rst = 1'b0; load = 1'b0;
    tick();
    vectors++;
    if (cw !== 4'd1) begin
      $display("FAIL v6_resume: got %0d expected 1", cw);
      miscompares++;
    end
    load = 1'b1; data = 4'd15;
    tick();
    load = 1'b0; rst = 1'b1;
    tick();
    vectors++;
    if ({cw, ow, uw} !== {4'd0, 1'b0, 1'b0}) begin
      $display("FAIL v6_rst_flag: got {cnt,ovf,unf}=%b expected 000000", {cw, ow, uw});
      miscompares++;
    end
    rst = 1'b0;
  endtask

  task automatic test_width8();
    up = 1'b0; down = 1'b0; load = 1'b1;
    data8 = 8'd100; step8 = 8'd200; max8 = 8'd255;
    tick();
    vectors++;
    if (c8 !== 8'd100) begin
      $display("FAIL v6_w8_load: got %0d expected 100", c8);
      miscompares++;
    end
    load = 1'b0; up = 1'b1;
    tick();
    vectors++;
    if ({c8, o8, u8} !== {8'd44, 1'b1, 1'b0}) begin
      $display("FAIL v6_w8_up: got cnt=%0d ovf=%b unf=%b expected cnt=44 ovf=1 unf=0", c8, o8, u8);
      miscompares++;
    end
    up = 1'b0;
  endtask

  task automatic test_step_edges();
    load = 1'b1; up = 1'b0; down = 1'b0; max_val = 4'd5; step = 4'd9; data = 4'd2;
    tick();
    load = 1'b0; up = 1'b1;
    tick();
    vectors++;
    if ({cw, ow, uw} !== {4'd1, 1'b1, 1'b0}) begin
      $display("FAIL step_clip: got {cnt,ovf,unf}=%b expected %b", {cw, ow, uw}, 6'b0001_10);
      miscompares++;
    end
    step = 4'd0;
    tick();
    vectors++;
    if ({cw, ow, uw} !== {4'd1, 1'b0, 1'b0}) begin
      $display("FAIL step_zero: got {cnt,ovf,unf}=%b expected %b", {cw, ow, uw}, 6'b0001_00);
      miscompares++;
    end
    up = 1'b0;
  endtask

  task automatic test_back_to_back();
    load = 1'b1; up = 1'b0; down = 1'b0; max_val = 4'd2; step = 4'd2; data = 4'd2;
    tick();
    load = 1'b0; up = 1'b1;
    tick();
    vectors++;
    if ({cw, ow, uw} !== {4'd1, 1'b1, 1'b0}) begin
      $display("FAIL b2b_first: got {cnt,ovf,unf}=%b expected %b", {cw, ow, uw}, 6'b0001_10);
      miscompares++;
    end
    tick();
    vectors++;
    if ({cw, ow, uw} !== {4'd0, 1'b1, 1'b0}) begin
      $display("FAIL b2b_second: got {cnt,ovf,unf}=%b expected %b", {cw, ow, uw}, 6'b0000_10);
      miscompares++;
    end
    load = 1'b1; up = 1'b0; max_val = 4'd0; step = 4'd1; data = 4'd7;
    tick();
    vectors++;
    if ({cw, amaxw, aminw} !== {4'd0, 1'b1, 1'b1}) begin
      $display("FAIL zero_load: got {cnt,atmax,atmin}=%b expected 000011", {cw, amaxw, aminw});
      miscompares++;
    end
    load = 1'b0;
    for (int i = 0; i < 4; i++) begin
      up = (i < 2); down = (i >= 2);
      tick();
      vectors++;
      if ({cw, ow, uw, cs, os, us} !== {4'd0, (i < 2), (i >= 2), 4'd0, (i < 2), (i >= 2)}) begin
        $display("FAIL zero_range%0d: got wrap=%0d/%b/%b sat=%0d/%b/%b expected 0/%b/%b both",
                 i, cw, ow, uw, cs, os, us, (i < 2), (i >= 2));
        miscompares++;
      end
    end
    up = 1'b0; down = 1'b0;
    tick();
    vectors++;
    if ({ow, uw, os, us} !== 4'b0000) begin
      $display("FAIL flag_drop: got %b expected 0000", {ow, uw, os, us});
      miscompares++;
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; load = 1'b0; up = 1'b0; down = 1'b0;
    data = '0; step = '0; max_val = '0;
    data8 = '0; step8 = '0; max8 = '0;
    test_reset();
    test_wrap_step1();
    test_wrap_step3();
    test_saturate();
    test_hold_priority();
    test_clamp();
    test_reset_midcount();
    test_width8();
    test_step_edges();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
